// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU-op codes, control constants, shift-class rule and sequencer states
package alu_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_FUNC = 2'd1,
        OP_SUB  = 2'd2,
        OP_RSV  = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_ITER   = 2'd2
    } state_e;

    localparam int unsigned NOP_CTRL = 0;
    localparam int unsigned SUB_CTRL = 1;

    // the top bit of the function field marks a shift-class instruction
    function automatic int shift_bit(input int func_w);
        return func_w - 1;
    endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALU-op/function decode and shift-class detection
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W = 5,
    parameter int CTRL_W = 4
) (
    input  logic [1:0]        alu_op,
    input  logic [FUNC_W-1:0] func_code,
    output logic [CTRL_W-1:0] ctrl,
    output logic              shift
);
    always_comb begin
        shift = alu_op == OP_FUNC && func_code[shift_bit(FUNC_W)];
        ctrl  = alu_op == OP_FUNC ? func_code[CTRL_W-1:0] :
                alu_op == OP_SUB  ? CTRL_W'(SUB_CTRL) : CTRL_W'(NOP_CTRL);
    end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control sequencer issuing one or more control beats per decoded instruction
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W  = 5,
    parameter int CTRL_W  = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [FUNC_W-1:0]  func_code,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               step_last,
    output logic               busy
);
    state_e              state, state_nx;
    logic [SHAMT_W-1:0]  cnt;
    logic [CTRL_W-1:0]   ctrl_q, dec_ctrl;
    logic                dec_shift, multi, last, in_fire, out_fire;

    alu_ctrl_decode #(.FUNC_W(FUNC_W), .CTRL_W(CTRL_W)) u_decode (
        .alu_op    (alu_op),
        .func_code (func_code),
        .ctrl      (dec_ctrl),
        .shift     (dec_shift)
    );

    assign multi    = dec_shift && shamt > SHAMT_W'(1);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign alu_ctrl = ctrl_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;

    always_comb
        state_nx = in_fire             ? (multi ? ST_ITER : ST_SINGLE) :
                   (out_fire && last)  ? ST_IDLE : state;

    always_comb begin
        out_valid = state != ST_IDLE;
        busy      = state == ST_ITER;
        last      = state == ST_SINGLE || (state == ST_ITER && cnt == SHAMT_W'(1));
        step_last = last;
        in_ready  = !out_valid || (out_ready && last);
    end

    // cnt holds the beats still to issue, including the one on the output now
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt    <= '0;
            ctrl_q <= CTRL_W'(NOP_CTRL);
        end else if (in_fire) begin
            cnt    <= multi ? shamt : '0;
            ctrl_q <= (dec_shift && shamt == '0) ? CTRL_W'(NOP_CTRL) : dec_ctrl;
        end else if (out_fire) begin
            cnt    <= last ? '0 : cnt - SHAMT_W'(1);
            ctrl_q <= last ? CTRL_W'(NOP_CTRL) : ctrl_q;
        end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: randomized and directed checks of alu_ctrl_seq against a beat-queue model
module tb_alu_ctrl_seq;
    logic       clk = 0, rst = 0, in_valid = 0, out_ready = 1;
    logic [1:0] alu_op = 0;
    logic [4:0] func_code = 0, shamt = 0;
    logic       in_ready, out_valid, step_last, busy;
    logic [3:0] alu_ctrl;
    int         tests = 0, fails = 0;

    typedef struct {
        int c;
        bit last;
        bit busy;
    } beat_t;
    beat_t q[$];

    alu_ctrl_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .func_code(func_code), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
        .step_last(step_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string n, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // model: an instruction expands into a list of beats; the head beat is what must be on the output
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_alu_ctrl", alu_ctrl, 0);
            chk("rst_busy", busy, 0);
            chk("rst_step_last", step_last, 0);
        end else begin
            bit ready, sh;
            int n, c;
            chk("m_out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("m_alu_ctrl", alu_ctrl, q[0].c);
                chk("m_step_last", step_last, q[0].last);
                chk("m_busy", busy, q[0].busy);
            end else
                chk("m_busy_idle", busy, 0);
            ready = q.size() == 0 || (out_ready && q.size() == 1);
            chk("m_in_ready", in_ready, ready);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && ready) begin
                sh = alu_op == 1 && func_code[4];
                n  = (sh && shamt > 1) ? int'(shamt) : 1;
                c  = alu_op == 1 ? ((sh && shamt == 0) ? 0 : int'(func_code[3:0])) :
                     alu_op == 2 ? 1 : 0;
                for (int k = 1; k <= n; k++) q.push_back('{c, k == n, n > 1});
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [4:0] f, input logic [4:0] s);
        bit took;
        alu_op = op; func_code = f; shamt = s; in_valid = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!out_valid) return;
            if (out_ready) n++;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int lit[4] = '{0, 6, 1, 0};
        // reset held with toggling inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom); alu_op = 2'($urandom);
            func_code = 5'($urandom); shamt = 5'($urandom); out_ready = 1'($urandom);
        end
        @(negedge clk);
        #2;
        in_valid = 0; out_ready = 1; rst = 1;
        #1 chk("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // decode sweep
        for (int op = 0; op < 4; op++) begin
            send(2'(op), 5'b00110, 5'd7);
            in_valid = 0;
            @(negedge clk);
            chk("sweep_ctrl", alu_ctrl, lit[op]);
            chk("sweep_last", step_last, 1);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("sweep_one_beat", out_valid, 0);
            @(posedge clk);
            #1;
        end

        // four-beat shift
        send(2'd1, 5'b10011, 5'd4);
        in_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("sh4_ctrl", alu_ctrl, 3);
            chk("sh4_last", step_last, k == 4);
            chk("sh4_busy", busy, 1);
            chk("sh4_in_ready", in_ready, k == 4);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("sh4_done_valid", out_valid, 0);
        chk("sh4_done_busy", busy, 0);
        @(posedge clk);
        #1;

        // backpressure mid-sequence
        send(2'd1, 5'b10010, 5'd3);
        in_valid = 0;
        @(negedge clk);
        chk("bp_b1_ctrl", alu_ctrl, 2);
        @(posedge clk);
        #1;
        out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ctrl", alu_ctrl, 2);
            chk("bp_hold_last", step_last, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        drain(n);
        chk("bp_beats", n + 1, 3);

        // shift shamt=0 is a single NOP beat
        send(2'd1, 5'b10111, 5'd0);
        in_valid = 0;
        @(negedge clk);
        chk("sh0_ctrl", alu_ctrl, 0);
        chk("sh0_last", step_last, 1);
        @(posedge clk);
        #1;
        drain(n);
        chk("sh0_extra", n, 0);

        // maximum shift amount
        send(2'd1, 5'b11001, 5'd31);
        in_valid = 0;
        drain(n);
        chk("sh31_beats", n, 31);

        // back-to-back single-beat instructions, then shift with no bubble
        send(2'd0, 5'b00001, 5'd2);
        send(2'd1, 5'b00101, 5'd9);
        send(2'd2, 5'b10001, 5'd3);
        send(2'd1, 5'b10110, 5'd1);
        send(2'd1, 5'b10100, 5'd2);
        in_valid = 0;
        drain(n);
        chk("b2b_tail", n, 2);

        // reset during beat 2 of a five-beat shift
        send(2'd1, 5'b10101, 5'd5);
        in_valid = 0;
        @(negedge clk);
        @(posedge clk);
        #3;
        chk("mr_pre_ctrl", alu_ctrl, 5);
        rst = 0;
        #1;
        chk("mr_async_valid", out_valid, 0);
        chk("mr_async_ctrl", alu_ctrl, 0);
        chk("mr_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk("mr_rel_ready", in_ready, 1);
        chk("mr_rel_valid", out_valid, 0);
        @(posedge clk);
        #1;
        drain(n);
        chk("mr_residual", n, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            alu_op    = 2'($urandom);
            func_code = 5'($urandom);
            shamt     = $urandom_range(0, 5) == 0 ? 5'($urandom) : 5'($urandom_range(0, 4));
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        out_ready = 1;
        drain(n);
        @(negedge clk);
        chk("final_idle", out_valid, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
